fib_engine: RTL and testbench
=============================

// Module: fib_engine
// PURPOSE
//   Parametrised Fibonacci engine on a shared tri-state register bus; successor of the 8-bit two-register fib block.
//   Host loads seeds into reg 0/1 over data/address/we/oe, pulses start; engine ping-pongs reg0/reg1 with
//   x[n+1]=x[n]+x[n-1] until carry-out, keeps a step count in reg NREGS-1, flags overflow, pulses done.
// PARAMETERS
//   WIDTH  8  data/register width in bits (>=2)
//   NREGS  4  register-file depth (>=3); AW = $clog2(NREGS)
// PORTS
//   clk         in     1      rising-edge clock
//   reset       in     1      synchronous, active-high reset
//   data        inout  WIDTH  shared bus; host drives only when busy=0
//   address     in     AW     host register select (ignored while busy)
//   we          in     1      host write strobe (ignored while busy)
//   oe          in     1      host read enable (ignored while busy)
//   start       in     1      begin run; sampled only when busy=0
//   busy        out    1      state != IDLE
//   done        out    1      1-cycle pulse on return to IDLE
//   ovf         out    1      sticky: last run ended on carry-out; cleared by start
//   step_limit  in     WIDTH  only with FIB_STEP_LIMIT_EN
// BEHAVIOUR
//   Reset: regs=0, state=IDLE, busy=0, done=0, ovf=0, addr_i=0, engine bus driver off (data=Z).
//   Bus: reg k drives data when oe_c && addr_c==k; engine drives only in WROTE; else Z.
//     addr_c/we_c/oe_c = engine-internal when busy, host inputs when idle.
//   Host (idle): we && !oe writes data into reg[address]; we&&oe -> write dropped; address>=NREGS -> reads Z, writes dropped.
//   FSM: IDLE -start-> READ_FIRST: addr_i<=0, oe_i<=1, count reg (NREGS-1)<=0, ovf<=0.
//     READ_FIRST : tmp<=data; toggle addr_i; -> READ_SECOND.
//     READ_SECOND: sum={1'b0,tmp}+data (WIDTH+1 bits); toggle addr_i;
//        sum[WIDTH]=1 -> oe_i<=0, ovf<=1, -> IDLE (no write, count unchanged);
//        else data_i<=sum[WIDTH-1:0], we_i<=1, oe_i<=0 -> WROTE.
//     WROTE: reg[addr_i]<=data_i (overwrites older value); count+1 saturating at all-ones;
//        we_i<=0, oe_i<=1, toggle addr_i, -> READ_FIRST.
//   Only addresses 0/1 used by engine; count reg written internally, not over bus.
//   Latency: 3 cycles per step, +2 for terminating read pair; done pulses the cycle after the
//     final transition (busy=0 same cycle as done).
//   start while busy: ignored. Reset mid-run: immediate return to reset state, no done pulse.
//   Seeds 0,0 (or any non-overflowing sequence): runs until reset; count saturates, ovf stays 0.
// CONFIGURATION
//   FIB_STEP_LIMIT_EN defined: step_limit port exists; in WROTE, if step_limit!=0 and the
//     post-increment count==step_limit, -> IDLE with done pulse, ovf=0. step_limit=0 = unlimited.
//     Sampled each WROTE cycle.
//   Undefined: no port; runs terminate only on overflow or reset.
// TESTING
//   1 WIDTH=8: seeds r0=1,r1=1, start -> busy 35 cycles, ovf=1, done once; r0=233, r1=144, r3=11.
//   2 WIDTH=8: seeds 200,100 -> busy 2 cycles, ovf=1, r0/r1 unchanged, r3=0.
//   3 WIDTH=16: seeds 1,1 -> r0=28657, r1=46368, r3=22, ovf=1.
//   4 WIDTH=8: seeds 0,0, run 1000 cycles -> busy=1, r3=255, ovf=0; reset -> all regs 0, busy=0, no done.
//   5 start pulses during run 1 plus host we to addr 0 -> no restart, r0 unaffected; address=4 (NREGS=4,AW=2
//     n/a) -> use NREGS=5, address 5..7 reads Z, writes dropped.
//   6 FIB_STEP_LIMIT_EN, step_limit=3, seeds 1,1 -> busy 9 cycles, r0=5, r1=3, r3=3, ovf=0, done once.

Source files
------------

// File: rtl/fib_engine.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | fib_engine : Fibonacci engine on a shared tri-state register bus; runs until |
// | carry-out (optional FIB_STEP_LIMIT_EN step cap). Rev 1.0                     |
// +------------------------------------------------------------------------------+
module fib_engine #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [WIDTH-1:0] data,
    input  logic [AW-1:0]    address,
    input  logic             we,
    input  logic             oe,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             ovf
`ifdef FIB_STEP_LIMIT_EN
    ,
    input  logic [WIDTH-1:0] step_limit
`endif
);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_READ_FIRST  = 2'd1,
        S_READ_SECOND = 2'd2,
        S_WROTE       = 2'd3
    } state_t;

    localparam int              CNT_IDX = NREGS - 1;
    localparam logic [AW:0]     NREGS_W = (AW + 1)'(NREGS);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_regs [NREGS];
    logic [WIDTH-1:0] r_tmp;
    logic [WIDTH-1:0] r_wdata;
    logic             r_eng_addr;
    logic             r_done;
    logic             r_ovf;

    logic [AW-1:0]    w_addr_c;
    logic             w_oe_c;
    logic             w_we_c;
    logic             w_addr_ok;
    logic [WIDTH-1:0] w_rd_data;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_cnt_inc;
    logic             w_limit_hit;
    logic             w_finish;
    logic             w_drv_en;
    logic [WIDTH-1:0] w_drv_val;

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign ovf  = r_ovf;

    // The engine owns the bus controls while busy; host strobes are ignored then.
    assign w_addr_c  = busy ? {{(AW-1){1'b0}}, r_eng_addr} : address;
    assign w_oe_c    = busy ? (r_state == S_READ_FIRST || r_state == S_READ_SECOND) : oe;
    assign w_we_c    = busy ? (r_state == S_WROTE) : we;
    assign w_addr_ok = ({1'b0, w_addr_c} < NREGS_W);
    assign w_rd_data = r_regs[w_addr_c];

    assign w_drv_en  = (w_oe_c && w_addr_ok) || (r_state == S_WROTE);
    assign w_drv_val = (r_state == S_WROTE) ? r_wdata : w_rd_data;
    assign data      = w_drv_en ? w_drv_val : {WIDTH{1'bz}};

    assign w_sum     = {1'b0, r_tmp} + {1'b0, w_rd_data};
    assign w_cnt_inc = (r_regs[CNT_IDX] == CNT_MAX) ? CNT_MAX
                                                    : r_regs[CNT_IDX] + WIDTH'(1);

`ifdef FIB_STEP_LIMIT_EN
    assign w_limit_hit = (step_limit != '0) && (w_cnt_inc == step_limit);
`else
    assign w_limit_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_READ_FIRST;
                end
            end
            S_READ_FIRST: begin
                w_state_next = S_READ_SECOND;
            end
            S_READ_SECOND: begin
                if (w_sum[WIDTH]) begin
                    w_state_next = S_IDLE;
                    w_finish     = 1'b1;
                end else begin
                    w_state_next = S_WROTE;
                end
            end
            S_WROTE: begin
                if (w_limit_hit) begin
                    w_state_next = S_IDLE;
                    w_finish     = 1'b1;
                end else begin
                    w_state_next = S_READ_FIRST;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
            r_tmp      <= '0;
            r_wdata    <= '0;
            r_eng_addr <= 1'b0;
            r_done     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_done <= w_finish;
            case (r_state)
                S_IDLE: begin
                    if (w_we_c && !w_oe_c && w_addr_ok) begin
                        r_regs[w_addr_c] <= data;
                    end
                    if (start) begin
                        r_eng_addr       <= 1'b0;
                        r_regs[CNT_IDX]  <= '0;
                        r_ovf            <= 1'b0;
                    end
                end
                S_READ_FIRST: begin
                    r_tmp      <= w_rd_data;
                    r_eng_addr <= ~r_eng_addr;
                end
                S_READ_SECOND: begin
                    r_eng_addr <= ~r_eng_addr;
                    if (w_sum[WIDTH]) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_wdata <= w_sum[WIDTH-1:0];
                    end
                end
                S_WROTE: begin
                    // Overwrites the older of the two operands, so reg0/reg1 ping-pong.
                    r_regs[{{(AW-1){1'b0}}, r_eng_addr}] <= r_wdata;
                    r_regs[CNT_IDX]                      <= w_cnt_inc;
                    r_eng_addr                           <= ~r_eng_addr;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fib_engine.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | tb_fib_engine : scoreboard bench for fib_engine (WIDTH=8, NREGS=5).          |
// | Rev 1.0                                                                      |
// +------------------------------------------------------------------------------+
module tb_fib_engine;

    localparam int WIDTH = 8;
    localparam int NREGS = 5;
    localparam int AW    = $clog2(NREGS);
    localparam int CNT   = NREGS - 1;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [AW-1:0]    address;
    logic             we;
    logic             oe;
    logic             start;
    logic             busy;
    logic             done;
    logic             ovf;
    logic             tb_drv;
    logic [WIDTH-1:0] tb_val;
    wire  [WIDTH-1:0] data;
`ifdef FIB_STEP_LIMIT_EN
    logic [WIDTH-1:0] step_limit;
`endif

    assign data = tb_drv ? tb_val : {WIDTH{1'bz}};

    fib_engine #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .address    (address),
        .we         (we),
        .oe         (oe),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf)
`ifdef FIB_STEP_LIMIT_EN
        ,
        .step_limit (step_limit)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int cycles;
        int ov;
    } run_t;

    run_t run_q[$];
    int   rd_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   model_regs[NREGS];
    int   busy_cnt = 0;

    task automatic chk(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Reference: repeatedly add the two seed registers, writing the sum over reg0, reg1, reg0, ...
    function automatic void model_run(input int limit, output int cycles, output int ov);
        int idx   = 0;
        int steps = 0;
        int s;
        model_regs[CNT] = 0;
        ov     = 0;
        cycles = 0;
        for (int it = 0; it < 100000; it++) begin
            s = model_regs[0] + model_regs[1];
            if (s > MAXV) begin
                ov     = 1;
                cycles = steps * 3 + 2;
                return;
            end
            model_regs[idx] = s;
            idx   = 1 - idx;
            steps = steps + 1;
            if (model_regs[CNT] < MAXV) model_regs[CNT] = model_regs[CNT] + 1;
            if (limit != 0 && model_regs[CNT] == limit) begin
                cycles = steps * 3;
                return;
            end
        end
    endfunction

    // Monitor: pops expectations whenever the DUT presents a read or a done pulse.
    always @(negedge clk) begin
        run_t r;
        int   exp;
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (!busy && oe && !we && int'(address) < NREGS && rd_q.size() != 0) begin
                exp = rd_q.pop_front();
                chk($sformatf("read_r%0d", address), int'(data), exp);
            end
            if (done) begin
                if (run_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    r = run_q.pop_front();
                    chk("busy_cycles", busy_cnt, r.cycles);
                    chk("ovf_at_done", int'(ovf), r.ov);
                    chk("busy_at_done", int'(busy), 0);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int a, input int v);
        address = AW'(a);
        tb_val  = WIDTH'(v);
        tb_drv  = 1'b1;
        we      = 1'b1;
        oe      = 1'b0;
        tick();
        we      = 1'b0;
        tb_drv  = 1'b0;
        if (a < NREGS) model_regs[a] = v & MAXV;
    endtask

    task automatic host_read(input int a);
        if (a < NREGS) rd_q.push_back(model_regs[a]);
        address = AW'(a);
        we      = 1'b0;
        oe      = 1'b1;
        tick();
        oe      = 1'b0;
    endtask

    task automatic read_all();
        for (int a = 0; a < NREGS; a++) host_read(a);
    endtask

    task automatic wait_idle(input string nm);
        int k = 0;
        while (run_q.size() != 0 && k < 5000) begin
            tick();
            k++;
        end
        if (run_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got no done after %0d cycles expected done", nm, k);
            run_q.delete();
        end
    endtask

    // Starts a run; when disturb is set, start and host we are pulsed while busy.
    task automatic run(input int limit, input int disturb, input string nm);
        run_t r;
        int   eff;
`ifdef FIB_STEP_LIMIT_EN
        eff        = limit;
        step_limit = WIDTH'(limit);
`else
        eff = 0 * limit;
`endif
        model_run(eff, r.cycles, r.ov);
        run_q.push_back(r);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (disturb != 0) begin
            tick();
            tick();
            address = '0;
            tb_drv  = 1'b0;
            we      = 1'b1;
            start   = 1'b1;
            repeat (6) tick();
            we      = 1'b0;
            start   = 1'b0;
        end
        wait_idle(nm);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int b;
        reset   = 1'b1;
        we      = 1'b0;
        oe      = 1'b0;
        start   = 1'b0;
        address = '0;
        tb_drv  = 1'b0;
        tb_val  = '0;
`ifdef FIB_STEP_LIMIT_EN
        step_limit = '0;
`endif
        for (int k = 0; k < NREGS; k++) model_regs[k] = 0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_ovf", int'(ovf), 0);
        read_all();

        // Seeds 1,1 with start/write pulses while busy: 11 steps, overflow on 233+144.
        host_write(0, 1);
        host_write(1, 1);
        run(0, 1, "seeds_1_1");
        chk("ovf_sticky", int'(ovf), 1);
        read_all();

        // Immediate overflow: registers untouched, count cleared by start.
        host_write(CNT, 77);
        host_write(0, 200);
        host_write(1, 100);
        run(0, 0, "seeds_200_100");
        read_all();

        // Out-of-range addresses: writes dropped, reads return nothing.
        host_write(2, 8'h5A);
        host_write(3, 8'hC3);
        for (int k = NREGS; k < (1 << AW); k++) begin
            host_write(k, 8'hFF);
            host_read(k);
        end
        read_all();

`ifdef FIB_STEP_LIMIT_EN
        host_write(0, 1);
        host_write(1, 1);
        run(3, 0, "step_limit_3");
        chk("ovf_after_limit", int'(ovf), 0);
        read_all();
`endif

        for (int it = 0; it < 20; it++) begin
            host_write($urandom_range(0, (1 << AW) - 1), $urandom_range(0, MAXV));
            host_read($urandom_range(0, (1 << AW) - 1));
            a = $urandom_range(0, MAXV);
            b = $urandom_range(0, MAXV);
            if (a == 0 && b == 0) b = 1;
            host_write(0, a);
            host_write(1, b);
            run($urandom_range(0, 6), 0, "random_run");
            read_all();
        end

        // Seeds 0,0 never overflow: count saturates, then reset aborts the run silently.
        host_write(2, 8'h33);
        host_write(0, 0);
        host_write(1, 0);
`ifdef FIB_STEP_LIMIT_EN
        step_limit = '0;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (1000) tick();
        chk("zero_busy", int'(busy), 1);
        chk("zero_ovf", int'(ovf), 0);
        chk("zero_count_sat", int'(dut.r_regs[CNT]), MAXV);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < NREGS; k++) model_regs[k] = 0;
        chk("midrun_reset_busy", int'(busy), 0);
        chk("midrun_reset_ovf", int'(ovf), 0);
        repeat (4) tick();
        read_all();
        tick();
        chk("read_queue_drained", rd_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
